// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART TX (and future RX).
//   - parity mode codes used by the PARITY_MODE parameter
//   - frame FSM state type
//   - calcParity: parity of a payload word, zero-extended to 9 bits
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } txState_t;

   // Unused upper bits must be zero; they do not disturb the XOR.
   function automatic logic calcParity(input logic [8:0] word, input int unsigned mode);
      return (mode == PARITY_ODD) ? ~^word : ^word;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter.
//   clk      system clock
//   rst      asynchronous reset, active-high (counter to 0)
//   restart  hold/reload the counter at START_OFFSET
//   bit_end  high during the last clock of each bit period
// The count runs 0..CLKS_PER_BIT-1 and wraps, so consecutive bit periods
// are exactly CLKS_PER_BIT cycles. START_OFFSET lets the RX sample mid-bit.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned START_OFFSET = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic bit_end
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] LOAD_CNT = CW'(START_OFFSET);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= LOAD_CNT;
      end else if (cnt == LAST_CNT) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bit_end = (cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Frame: start(0), DATA_BITS payload LSB-first, optional parity, STOP_BITS stop(1).
// Ports:
//   i_clkTx    system clock
//   i_rstTx    asynchronous reset, active-high
//   i_validTx  source presents a word on i_bitsTx
//   i_bitsTx   payload word (DATA_BITS wide)
//   o_readyTx  block can accept a word (transfer on i_validTx && o_readyTx)
//   o_dataTx   serial line, idle 1
//   o_busyTx   frame in progress
//   o_doneTx   one-cycle pulse after the final stop bit
// Build option UART_TX_HOLD_EN: one-entry holding register, so a word can be
// accepted mid-frame and the next frame follows the stop bit with no idle cycle.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_MODE  = 1,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 i_clkTx,
   input  logic                 i_rstTx,
   input  logic                 i_validTx,
   input  logic [DATA_BITS-1:0] i_bitsTx,
   output logic                 o_readyTx,
   output logic                 o_dataTx,
   output logic                 o_busyTx,
   output logic                 o_doneTx
);

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE > 2 ||
       (STOP_BITS != 1 && STOP_BITS != 2)) begin : gBadParam
      $error("uart_tx_param: parameter out of range");
   end

   localparam int unsigned IW = $clog2(DATA_BITS + 1);
   localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
   localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);

   txState_t             state, stateNext;
   logic [DATA_BITS-1:0] shiftReg;
   logic [DATA_BITS-1:0] srcWord;
   logic                 parityBit;
   logic [IW-1:0]        bitIdx;
   logic                 armed;       // low until the first edge after reset
   logic                 bitEnd;
   logic                 accept;
   logic                 startFrame;
   logic                 frameEnd;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) bitTimer (
      .clk     (i_clkTx),
      .rst     (i_rstTx),
      .restart (state == IDLE),
      .bit_end (bitEnd)
   );

`ifdef UART_TX_HOLD_EN
   logic [DATA_BITS-1:0] holdReg;
   logic                 holdFull;

   assign o_readyTx = armed & ~holdFull;
   // A pending held word takes priority; holdFull is only set outside IDLE.
   assign srcWord   = holdFull ? holdReg : i_bitsTx;
`else
   assign o_readyTx = armed & (state == IDLE);
   assign srcWord   = i_bitsTx;
`endif

   assign accept = i_validTx & o_readyTx;

   always_ff @(posedge i_clkTx or posedge i_rstTx) begin
      if (i_rstTx) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext  = state;
      o_dataTx   = 1'b1;
      o_busyTx   = 1'b1;
      startFrame = 1'b0;
      frameEnd   = 1'b0;
      case (state)
         IDLE: begin
            o_busyTx = 1'b0;
            if (accept) begin
               stateNext  = START;
               startFrame = 1'b1;
            end
         end
         START: begin
            o_dataTx = 1'b0;
            if (bitEnd) stateNext = DATA;
         end
         DATA: begin
            o_dataTx = shiftReg[0];
            if (bitEnd && bitIdx == LAST_DATA) stateNext = HAS_PARITY ? PARITY : STOP;
         end
         PARITY: begin
            o_dataTx = parityBit;
            if (bitEnd) stateNext = STOP;
         end
         STOP: begin
            if (bitEnd && bitIdx == LAST_STOP) begin
               frameEnd  = 1'b1;
               stateNext = IDLE;
`ifdef UART_TX_HOLD_EN
               // Chain straight into the next start bit when a word is waiting
               // (held, or arriving on this very edge).
               if (holdFull || accept) begin
                  stateNext  = START;
                  startFrame = 1'b1;
               end
`endif
            end
         end
         default: begin
            o_busyTx  = 1'b0;
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clkTx or posedge i_rstTx) begin
      if (i_rstTx) begin
         shiftReg  <= '0;
         parityBit <= 1'b0;
         bitIdx    <= '0;
         armed     <= 1'b0;
         o_doneTx  <= 1'b0;
      end else begin
         armed    <= 1'b1;
         o_doneTx <= frameEnd;
         if (startFrame) begin
            shiftReg  <= srcWord;
            parityBit <= calcParity(9'(srcWord), PARITY_MODE);
            bitIdx    <= '0;
         end else if (bitEnd && state == DATA) begin
            shiftReg <= shiftReg >> 1;
            bitIdx   <= (bitIdx == LAST_DATA) ? '0 : bitIdx + 1'b1;
         end else if (bitEnd && state == STOP) begin
            bitIdx   <= (bitIdx == LAST_STOP) ? '0 : bitIdx + 1'b1;
         end
      end
   end

`ifdef UART_TX_HOLD_EN
   always_ff @(posedge i_clkTx or posedge i_rstTx) begin
      if (i_rstTx) begin
         holdReg  <= '0;
         holdFull <= 1'b0;
      end else if (accept && !startFrame) begin
         holdReg  <= i_bitsTx;
         holdFull <= 1'b1;
      end else if (startFrame) begin
         holdFull <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (even/1 stop, odd/2 stop,
// 7-bit no parity) at CLKS_PER_BIT=4. Expected line values are queued per
// clock when a word is accepted and popped as the line is sampled.
module tb_uart_tx_param;

   localparam int CPB = 4;

   logic clk = 1'b0;
   logic rst;
   logic [2:0]      vld;
   logic [2:0][8:0] bits;
   logic [2:0]      rdy, txd, bsy, dn;

   int nChecks = 0;
   int nFails  = 0;

   typedef struct packed {
      logic bitVal;
      logic isLast;
   } slot_t;
   slot_t expQ[$];

   always #5 clk = ~clk;

   uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dutEven (
      .i_clkTx(clk), .i_rstTx(rst), .i_validTx(vld[0]), .i_bitsTx(bits[0][7:0]),
      .o_readyTx(rdy[0]), .o_dataTx(txd[0]), .o_busyTx(bsy[0]), .o_doneTx(dn[0]));

   uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) dutOdd (
      .i_clkTx(clk), .i_rstTx(rst), .i_validTx(vld[1]), .i_bitsTx(bits[1][7:0]),
      .o_readyTx(rdy[1]), .o_dataTx(txd[1]), .o_busyTx(bsy[1]), .o_doneTx(dn[1]));

   uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(1)) dutSeven (
      .i_clkTx(clk), .i_rstTx(rst), .i_validTx(vld[2]), .i_bitsTx(bits[2][6:0]),
      .o_readyTx(rdy[2]), .o_dataTx(txd[2]), .o_busyTx(bsy[2]), .o_doneTx(dn[2]));

   function automatic int dwOf(input int k);
      return (k == 2) ? 7 : 8;
   endfunction
   function automatic int pmOf(input int k);
      return (k == 0) ? 1 : (k == 1) ? 2 : 0;
   endfunction
   function automatic int sbOf(input int k);
      return (k == 1) ? 2 : 1;
   endfunction

   // Queue the per-clock line values of one frame for instance k.
   task automatic pushFrame(input int k, input logic [8:0] w);
      logic b[$];
      int   ones = 0;
      b.push_back(1'b0);
      for (int i = 0; i < dwOf(k); i++) begin
         b.push_back(w[i]);
         if (w[i]) ones++;
      end
      if (pmOf(k) == 1) b.push_back((ones % 2) == 1);
      else if (pmOf(k) == 2) b.push_back((ones % 2) == 0);
      for (int i = 0; i < sbOf(k); i++) b.push_back(1'b1);
      for (int i = 0; i < b.size(); i++)
         for (int j = 0; j < CPB; j++)
            expQ.push_back('{bitVal: b[i], isLast: (i == b.size() - 1) && (j == CPB - 1)});
   endtask

   // Run nCycles clocks on instance k. Each accepted word pushes its frame;
   // after the first accept bits switch to altWord, after the last vld drops.
   task automatic stream(input int k, input int nCycles, input int nAccepts,
                         input logic [8:0] altWord, input bit drain, output int nDone);
      int   left = nAccepts;
      logic prevLast = 1'b0;
      logic expLine, expBusy, expDone;
      slot_t s;
      nDone = 0;
      for (int c = 0; c < nCycles; c++) begin
         @(negedge clk);
         expDone = prevLast;
         if (expQ.size() > 0) begin
            s = expQ.pop_front();
            expLine = s.bitVal; expBusy = 1'b1; prevLast = s.isLast;
         end else begin
            expLine = 1'b1; expBusy = 1'b0; prevLast = 1'b0;
         end
         nChecks++;
         if (txd[k] !== expLine) begin
            nFails++;
            $display("FAIL line dut%0d cycle %0d: got %b expected %b", k, c, txd[k], expLine);
         end
         nChecks++;
         if (bsy[k] !== expBusy) begin
            nFails++;
            $display("FAIL busy dut%0d cycle %0d: got %b expected %b", k, c, bsy[k], expBusy);
         end
         nChecks++;
         if (dn[k] !== expDone) begin
            nFails++;
            $display("FAIL done dut%0d cycle %0d: got %b expected %b", k, c, dn[k], expDone);
         end
`ifndef UART_TX_HOLD_EN
         nChecks++;
         if (rdy[k] !== !expBusy) begin
            nFails++;
            $display("FAIL ready dut%0d cycle %0d: got %b expected %b", k, c, rdy[k], !expBusy);
         end
`endif
         if (dn[k] === 1'b1) nDone++;
         if (vld[k] && rdy[k] && left > 0) begin
            pushFrame(k, bits[k]);
            left--;
            @(posedge clk);
            #1;
            if (left == 0) begin
               vld[k]  = 1'b0;
               bits[k] = 9'h155;
            end else begin
               bits[k] = altWord;
            end
         end
      end
      nChecks++;
      if (left != 0) begin
         nFails++;
         $display("FAIL accepts dut%0d: got %0d expected %0d", k, nAccepts - left, nAccepts);
      end
      if (drain) begin
         nChecks++;
         if (expQ.size() != 0) begin
            nFails++;
            $display("FAIL frame_len dut%0d: %0d expected slots left, expected 0", k, expQ.size());
         end
      end
      expQ.delete();
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      vld  = '0;
      bits = '0;
      #2;
      for (int k = 0; k < 3; k++) begin
         nChecks++;
         if ({txd[k], rdy[k], bsy[k], dn[k]} !== 4'b1000) begin
            nFails++;
            $display("FAIL reset_state dut%0d: got line/ready/busy/done %b expected 1000", k,
                     {txd[k], rdy[k], bsy[k], dn[k]});
         end
      end
      #20 rst = 1'b0;
      #2;
      nChecks++;
      if (rdy !== 3'b000) begin
         nFails++;
         $display("FAIL ready_before_edge: got %b expected 000", rdy);
      end
      @(posedge clk); #1;
      nChecks++;
      if (rdy !== 3'b111) begin
         nFails++;
         $display("FAIL ready_after_edge: got %b expected 111", rdy);
      end
   endtask

   task automatic sendOne(input int k, input logic [8:0] w, input int nCycles);
      int nd;
      @(posedge clk); #1;
      vld[k]  = 1'b1;
      bits[k] = w;
      stream(k, nCycles, 1, 9'h000, 1'b1, nd);
   endtask

   task automatic test_even_parity();
      sendOne(0, 9'h0A5, 48);
   endtask

   task automatic test_odd_two_stop();
      sendOne(1, 9'h0A5, 52);
   endtask

   task automatic test_seven_bits();
      sendOne(2, 9'h007, 40);
   endtask

   task automatic test_back_to_back();
      int nd;
      @(posedge clk); #1;
      vld[0]  = 1'b1;
      bits[0] = 9'h03C;
      stream(0, 96, 2, 9'h0C3, 1'b1, nd);
      nChecks++;
      if (nd != 2) begin
         nFails++;
         $display("FAIL b2b_done_count: got %0d expected 2", nd);
      end
   endtask

   task automatic test_reset_mid_frame();
      int nd;
      @(posedge clk); #1;
      vld[0]  = 1'b1;
      bits[0] = 9'h080;
      stream(0, 14, 1, 9'h000, 1'b0, nd);
      #2 rst = 1'b1;
      #1;
      nChecks++;
      if ({txd[0], rdy[0], bsy[0], dn[0]} !== 4'b1000) begin
         nFails++;
         $display("FAIL async_reset: got line/ready/busy/done %b expected 1000",
                  {txd[0], rdy[0], bsy[0], dn[0]});
      end
      repeat (2) begin
         @(negedge clk);
         nChecks++;
         if (dn[0] !== 1'b0 || txd[0] !== 1'b1) begin
            nFails++;
            $display("FAIL reset_hold: got done %b line %b expected 0 1", dn[0], txd[0]);
         end
      end
      rst = 1'b0;
      #1;
      nChecks++;
      if (rdy[0] !== 1'b0) begin
         nFails++;
         $display("FAIL ready_release: got %b expected 0", rdy[0]);
      end
      @(posedge clk); #1;
      nChecks++;
      if (rdy[0] !== 1'b1) begin
         nFails++;
         $display("FAIL ready_rearm: got %b expected 1", rdy[0]);
      end
      sendOne(0, 9'h05A, 48);
   endtask

`ifdef UART_TX_HOLD_EN
   task automatic test_hold();
      int nd;
      @(posedge clk); #1;
      vld[0]  = 1'b1;
      bits[0] = 9'h081;
      stream(0, 96, 2, 9'h03C, 1'b1, nd);
      nChecks++;
      if (nd != 2) begin
         nFails++;
         $display("FAIL hold_done_count: got %0d expected 2", nd);
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_even_parity();
      test_odd_two_stop();
      test_seven_bits();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_TX_HOLD_EN
      test_hold();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
